// File: rtl/msg_buf_if.sv
// Message buffer bus: write side, transmitter side, status flags and FSM debug state.
// Handshake: a write is taken at a rising clk edge where ready=1, flush=0 and
// full=0; a message is handed over at an edge where tx_ctrl=1, blue=0
// (presenting the head) and transmit_ready=1; flush overrides both.
interface msg_buf_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic              ready;
   logic [DATA_W-1:0] data;
   logic              transmit_ready;
   logic              flush;
   logic [DATA_W-1:0] tx_byte;
   logic              tx_ctrl;
   logic              blue;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [1:0]        state_dbg;

   // Producer / transmitter side (drives the buffer's inputs)
   modport master (
      output ready, data, transmit_ready, flush,
      input  tx_byte, tx_ctrl, blue, full, empty, count, overflow, state_dbg
   );

   // Buffer side
   modport slave (
      input  ready, data, transmit_ready, flush,
      output tx_byte, tx_ctrl, blue, full, empty, count, overflow, state_dbg
   );
endinterface

// File: rtl/msg_buf.sv
// Message buffer: circular FIFO feeding a transmitter through an
// IDLE -> WAIT -> TRANSMIT state machine that holds each message HOLD_CYC cycles.
module msg_buf #(
   parameter int                DATA_W    = 8,
   parameter int                DEPTH     = 4,
   parameter int                HOLD_CYC  = 1,
   parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b1}}
) (
   input logic     clk,
   input logic     rst,
   msg_buf_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT     = 2'd1,
      TRANSMIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [HCW-1:0]    hcnt_q, hcnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              push, pop, full_w;

   // Full is taken from the registered count, so a pop in the same cycle
   // never frees room for a write.
   assign full_w = (count_q == CW'(DEPTH));

   // Next-state, FIFO pointer and hold logic; flush overrides every other input
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      hold_d   = hold_q;
      hcnt_d   = hcnt_q;
      push     = 1'b0;
      pop      = 1'b0;
      if (bus.flush) begin
         state_d  = IDLE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         push = bus.ready && !full_w;
         if (bus.ready && full_w) ovf_d = 1'b1;
         case (state_q)
            IDLE: begin
               if (count_q != '0) state_d = WAIT;
            end
            WAIT: begin
               // WAIT is only ever entered with a nonempty FIFO
               if (bus.transmit_ready) begin
                  pop     = 1'b1;
                  hold_d  = mem_q[rd_ptr_q];
                  hcnt_d  = HCW'(HOLD_CYC - 1);
                  state_d = TRANSMIT;
               end
            end
            TRANSMIT: begin
               if (hcnt_q == '0) state_d = (count_q != '0) ? WAIT : IDLE;
               else              hcnt_d  = hcnt_q - 1'b1;
            end
            default: state_d = IDLE;
         endcase
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         hold_q   <= IDLE_WORD;
         hcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         hold_q   <= hold_d;
         hcnt_q   <= hcnt_d;
      end
   end

   // Message storage; entries are only read once count says they are valid
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= bus.data;
   end

   // Outputs decoded from registered state only
   always_comb begin
      bus.tx_ctrl = 1'b0;
      bus.blue    = 1'b0;
      bus.tx_byte = IDLE_WORD;
      case (state_q)
         WAIT: begin
            bus.tx_ctrl = 1'b1;
            bus.tx_byte = mem_q[rd_ptr_q];
         end
         TRANSMIT: begin
            bus.tx_ctrl = 1'b1;
            bus.blue    = 1'b1;
            bus.tx_byte = hold_q;
         end
         default: ;
      endcase
   end

   assign bus.full      = full_w;
   assign bus.empty     = (count_q == '0);
   assign bus.count     = count_q;
   assign bus.overflow  = ovf_q;
   assign bus.state_dbg = state_q;
endmodule

// File: doc/msg_buf.md
MSG_BUF -- requirements
Module: msg_buf

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the message byte width.
REQ-002 Parameter DEPTH, default 4, power of two and at least 2, SHALL set the number of queued messages.
REQ-003 Parameter HOLD_CYC, default 1, at least 1, SHALL set how many cycles each message is held in TRANSMIT.
REQ-004 Parameter IDLE_WORD, default all-ones of DATA_W, SHALL be the tx_byte value whenever no message is presented.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 ready  input  1  SHALL be the write strobe; data is sampled when ready=1.
REQ-008 data  input  DATA_W  SHALL be the message to enqueue.
REQ-009 transmit_ready  input  1  SHALL mean the transmitter accepts the presented message.
REQ-010 flush  input  1  SHALL discard all queued and in-flight messages.
REQ-011 tx_byte  output  DATA_W  SHALL be the message presented to the transmitter.
REQ-012 tx_ctrl  output  1  SHALL mean a valid message is presented.
REQ-013 blue  output  1  SHALL be the transmit-in-progress indicator (LED).
REQ-014 full, empty  output  1 each  SHALL give the FIFO occupancy flags.
REQ-015 count  output  $clog2(DEPTH+1)  SHALL give the number of queued messages, excluding the one in TRANSMIT.
REQ-016 overflow  output  1  SHALL be a sticky flag set when a write is dropped.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries with read and write pointers that wrap modulo DEPTH.
REQ-018 A write SHALL be accepted at the edge where ready=1, flush=0 and full=0; count increments after that edge.
REQ-019 A write attempted while full=1 SHALL be dropped and SHALL set overflow, including when a pop occurs in the same cycle.
REQ-020 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-021 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-022 The FSM SHALL have three states: IDLE, WAIT and TRANSMIT.
REQ-023 IDLE outputs SHALL be tx_ctrl=0, blue=0 and tx_byte=IDLE_WORD.
REQ-024 IDLE SHALL go to WAIT at the first edge where the registered count is nonzero, so tx_ctrl rises 2 edges after the write edge.
REQ-025 WAIT outputs SHALL be tx_ctrl=1, blue=0 and tx_byte equal to the FIFO head.
REQ-026 In WAIT with transmit_ready=1, at the edge the block SHALL copy the head into a hold register, pop the FIFO, load the hold counter with HOLD_CYC-1 and enter TRANSMIT; otherwise it stays in WAIT.
REQ-027 TRANSMIT outputs SHALL be tx_ctrl=1, blue=1 and tx_byte equal to the hold register.
REQ-028 TRANSMIT SHALL last exactly HOLD_CYC cycles, with the counter decrementing each cycle.
REQ-029 When the counter reaches 0, TRANSMIT SHALL exit to WAIT if count is nonzero, otherwise to IDLE.
REQ-030 transmit_ready SHALL be ignored in IDLE and TRANSMIT.
REQ-031 All outputs SHALL be derived from registered state only, with no combinational input-to-output path.
REQ-032 flush=1 SHALL, at the edge, empty the FIFO, clear overflow and force IDLE from any state, aborting TRANSMIT.
REQ-033 flush SHALL take priority over ready and transmit_ready.
REQ-034 Unreachable state encodings SHALL return to IDLE at the next edge.

Reset
REQ-035 rst=1 at an edge SHALL set state=IDLE, both pointers=0, count=0, overflow=0, hold counter=0 and hold register=IDLE_WORD.
REQ-036 After reset the outputs SHALL be tx_ctrl=0, blue=0, tx_byte=IDLE_WORD, empty=1 and full=0.
REQ-037 rst SHALL take priority over flush and all other inputs.
REQ-038 rst asserted mid-TRANSMIT SHALL abort the transmission with no pop or write completing at that edge.

Verification
REQ-039 Single message: reset; write 8'h41; hold transmit_ready=1 -> tx_ctrl rises 2 edges after the write with tx_byte=8'h41; blue=1 for 1 cycle; return to IDLE with tx_byte=8'hFF.
REQ-040 Fill and overflow: DEPTH=4 with transmit_ready=0; write 8'h01 through 8'h05 -> full=1 and count=4; 8'h05 is dropped and overflow=1; drain output order is 01, 02, 03, 04.
REQ-041 Hold and back-to-back: HOLD_CYC=3; queue 8'hA0 and 8'hA1 with transmit_ready=1 -> blue high for 3 cycles per message; WAIT lasts 1 cycle between them; tx_byte is A0 then A1.
REQ-042 Simultaneous push and pop at full: with count=4 in WAIT, ready=1 and transmit_ready=1 in the same cycle -> the write is dropped, overflow=1 and count becomes 3.
REQ-043 Flush mid-TRANSMIT: HOLD_CYC=4; assert flush in the 2nd TRANSMIT cycle -> IDLE next cycle, count=0, overflow=0 and tx_byte=IDLE_WORD.
REQ-044 Reset mid-operation: with 3 messages queued, assert rst together with ready=1 -> all REQ-036 output values hold and the write is not captured.
